restoring_divider: RTL and testbench



---
 rtl/restoring_divider.sv | 130 +++++++++++++
 tb/tb_restoring_divider.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// restoring_divider
// Sequential unsigned 8-bit by 4-bit restoring divider. It resolves one
// quotient bit per clock with a single 5-bit trial subtraction, so a
// nonzero-divisor operation takes 8 RUN cycles plus one DONE cycle.
// A zero divisor skips RUN and reports quotient 8'hFF, remainder 0 and
// the div_by_zero flag.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   start        request, sampled only in IDLE
//   dividend     8-bit unsigned dividend, captured on accept
//   divisor      4-bit unsigned divisor, captured on accept
//   quotient     registered quotient, updated on entry to DONE
//   remainder    registered remainder, updated on entry to DONE
//   busy         high while iterating (RUN)
//   done         one-cycle pulse in DONE
//   div_by_zero  registered flag: last result had a zero divisor
module restoring_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [4:0] pr;
  logic [7:0] q;
  logic [3:0] d;
  logic [2:0] cnt;

  logic       accept;
  logic [4:0] shifted;
  logic [5:0] diff;
  logic [4:0] pr_next;
  logic [7:0] q_next;

  assign accept = (state == IDLE) && start;

  // One restoring step. pr stays below d (<= 14), so pr[4] is always 0;
  // including it in the subtraction leaves the result unchanged and keeps
  // the full partial-remainder register in use. diff[5] is the borrow.
  always_comb begin
    shifted = {pr[3:0], q[7]};
    diff    = {pr, q[7]} - {2'b00, d};
    pr_next = diff[4:0];
    q_next  = {q[6:0], 1'b1};
    if (diff[5]) begin
      pr_next = shifted;
      q_next  = {q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (divisor == 4'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == 3'd7) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and result registers. Results only change on entry to DONE,
  // either from the last RUN iteration or directly on a zero divisor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr          <= 5'd0;
      q           <= 8'd0;
      d           <= 4'd0;
      cnt         <= 3'd0;
      quotient    <= 8'h00;
      remainder   <= 4'h0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      pr  <= 5'd0;
      q   <= dividend;
      d   <= divisor;
      cnt <= 3'd0;
      if (divisor == 4'd0) begin
        quotient    <= 8'hFF;
        remainder   <= 4'h0;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      pr  <= pr_next;
      q   <= q_next;
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) begin
        quotient    <= q_next;
        remainder   <= pr_next[3:0];
        div_by_zero <= 1'b0;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider
// Self-checking bench for restoring_divider. Expected results come from
// plain integer division in the bench; timing expectations (latency, busy
// length, single-cycle done, hold behaviour) come from the block's
// handshake description. Inputs are driven and outputs sampled on the
// falling edge.
module tb_restoring_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int checks;
  int errors;

  restoring_divider dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Issues one operation starting at a falling edge in IDLE and returns at
  // the falling edge of the IDLE cycle after done, ready for the earliest
  // next start. pa/pb give cycles (counted from the accept edge) at which
  // a stray 50/5 start request is pulsed; 0 means none.
  task automatic applyStimulus(input logic [7:0] a, input logic [3:0] b,
                               input int pa, input int pb);
    logic [7:0] expQ;
    logic [3:0] expR;
    logic       expZ;
    logic [7:0] prevQ;
    int         lat;
    int         busyCount;
    int         expLat;
    int         expBusy;
    logic       overlap;
    logic       holdBad;

    if (b == 4'd0) begin
      expQ    = 8'hFF;
      expR    = 4'd0;
      expZ    = 1'b1;
      expLat  = 1;
      expBusy = 0;
    end else begin
      expQ    = 8'(int'(a) / int'(b));
      expR    = 4'(int'(a) % int'(b));
      expZ    = 1'b0;
      expLat  = 9;
      expBusy = 8;
    end

    prevQ    = quotient;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);

    lat       = 1;
    busyCount = 0;
    overlap   = 1'b0;
    holdBad   = 1'b0;
    while (!done && lat < 20) begin
      if (busy) busyCount++;
      if (quotient != prevQ) holdBad = 1'b1;
      @(negedge clk);
      lat++;
      start = (lat == pa) || (lat == pb);
      if (start) begin
        dividend = 8'd50;
        divisor  = 4'd5;
      end
      if (busy && done) overlap = 1'b1;
    end

    checkOutput("latency", lat, expLat);
    checkOutput("busy_cycles", busyCount, expBusy);
    checkOutput("quotient", int'(quotient), int'(expQ));
    checkOutput("remainder", int'(remainder), int'(expR));
    checkOutput("div_by_zero", int'(div_by_zero), int'(expZ));
    checkOutput("busy_done_overlap", int'(overlap), 0);
    checkOutput("hold_prev", int'(holdBad), 0);

    @(negedge clk);
    start = 1'b0;
    checkOutput("done_one_cycle", int'(done), 0);
    checkOutput("idle_busy", int'(busy), 0);
    checkOutput("result_held", int'(quotient), int'(expQ));
  endtask

  task automatic waitQuiet(input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checkOutput("no_spurious_done", int'(seen), 0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 4'd0;

    repeat (2) @(negedge clk);
    checkOutput("rst_quotient", int'(quotient), 0);
    checkOutput("rst_remainder", int'(remainder), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed cases");
    applyStimulus(8'd200, 4'd7, 0, 0);
    applyStimulus(8'd255, 4'd1, 0, 0);
    applyStimulus(8'd255, 4'd15, 0, 0);
    applyStimulus(8'd5, 4'd9, 0, 0);
    applyStimulus(8'd0, 4'd3, 0, 0);
    applyStimulus(8'd77, 4'd0, 0, 0);
    applyStimulus(8'd77, 4'd4, 0, 0);

    $display("[TB] start ignored while busy or done");
    applyStimulus(8'd100, 4'd3, 3, 9);
    waitQuiet(12);

    $display("[TB] reset mid-operation");
    start    = 1'b1;
    dividend = 8'd180;
    divisor  = 4'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_quotient", int'(quotient), 0);
    checkOutput("mid_rst_remainder", int'(remainder), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_done", int'(done), 0);
    checkOutput("mid_rst_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;
    waitQuiet(12);
    applyStimulus(8'd180, 4'd11, 0, 0);

    $display("[TB] random operations");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(8'($urandom), 4'($urandom_range(0, 15)), 0, 0);
    end

    $display("[TB] exhaustive sweep");
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        applyStimulus(8'(a), 4'(b), 0, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
